// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style 4-bit bus responder that mirrors line 1 into a 16-char buffer
module lcd_bus_responder #(
    parameter int CmdCycles   = 2000,
    parameter int ClearCycles = 82000,
    parameter int CntW        = 17
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [11:8]   LCD_Data,
    input  logic          LCD_E,
    input  logic          LCD_RS,
    input  logic          LCD_RW,
    output logic [8*16:1] DisplayOut,
    output logic [6:0]    Addr,
    output logic          DisplayOn,
    output logic          Busy,
    output logic          WrStrobe,
    output logic [1:0]    ErrFlags
);
    typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO} state_t;
    state_t state, state_n;
    logic e_d, lat_rs, lat_rw, hi_rs, id, cgram;
    logic [3:0] lat_d, hi;
    logic [7:0] disp_buf [16];
    logic [CntW-1:0] cnt, cnt_n;
    logic [6:0] addr_n;
    logic id_n, cg_n, don_n, clr, wr, fall, nib_ev, exec;
    logic [1:0] err_n;
    logic [7:0] cmd;
    assign fall   = e_d & ~LCD_E;
    assign nib_ev = fall & ~lat_rw;
    assign exec   = nib_ev & (state == NIB_LO);
    assign cmd    = {hi, lat_d};
    assign Busy   = cnt != '0;
    genvar i;
    for (i = 0; i < 16; i++) begin : g_out
        assign DisplayOut[8*(16-i) -: 8] = disp_buf[i];
    end
    always_comb begin
        state_n = state;
        if (nib_ev)
            state_n = state == INIT8  ? ((!lat_rs && lat_d == 4'h2) ? NIB_HI : INIT8) :
                      state == NIB_HI ? NIB_LO : NIB_HI;
        // a nibble fall counts as busy even when the counter is on its last cycle
        err_n = ErrFlags | {(fall & lat_rw) | (exec & (lat_rs != hi_rs)),
                            nib_ev & (state != INIT8) & Busy};
    end
    always_comb begin
        addr_n = Addr;
        id_n   = id;
        cg_n   = cgram;
        don_n  = DisplayOn;
        clr    = 1'b0;
        wr     = 1'b0;
        cnt_n  = Busy ? cnt - CntW'(1) : cnt;
        if (exec) begin
            cnt_n = CntW'(CmdCycles);
            if (hi_rs) begin
                if (!cgram) begin
                    wr     = Addr < 7'd16;
                    addr_n = id ? Addr + 7'd1 : Addr - 7'd1;
                end
            end else if (cmd[7]) begin
                addr_n = cmd[6:0];
                cg_n   = 1'b0;
            end else if (cmd[6]) begin
                cg_n = 1'b1;
            end else if (cmd[5]) begin
                cg_n = cgram;
            end else if (cmd[4]) begin
                if (!cmd[3])
                    addr_n = cmd[2] ? Addr + 7'd1 : Addr - 7'd1;
            end else if (cmd[3]) begin
                don_n = cmd[2];
            end else if (cmd[2]) begin
                id_n = cmd[1];
            end else if (cmd[1]) begin
                addr_n = '0;
                cg_n   = 1'b0;
                cnt_n  = CntW'(ClearCycles);
            end else if (cmd[0]) begin
                clr    = 1'b1;
                addr_n = '0;
                id_n   = 1'b1;
                cg_n   = 1'b0;
                cnt_n  = CntW'(ClearCycles);
            end
        end
    end
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= INIT8;
            e_d       <= 1'b0;
            lat_d     <= '0;
            lat_rs    <= 1'b0;
            lat_rw    <= 1'b0;
            hi        <= '0;
            hi_rs     <= 1'b0;
            Addr      <= '0;
            id        <= 1'b1;
            cgram     <= 1'b0;
            DisplayOn <= 1'b0;
            cnt       <= '0;
            WrStrobe  <= 1'b0;
            ErrFlags  <= '0;
            for (int k = 0; k < 16; k++) disp_buf[k] <= 8'h20;
        end else begin
            state     <= state_n;
            e_d       <= LCD_E;
            if (LCD_E) begin
                lat_d  <= LCD_Data;
                lat_rs <= LCD_RS;
                lat_rw <= LCD_RW;
            end
            if (nib_ev && state == NIB_HI) begin
                hi    <= lat_d;
                hi_rs <= lat_rs;
            end
            Addr      <= addr_n;
            id        <= id_n;
            cgram     <= cg_n;
            DisplayOn <= don_n;
            cnt       <= cnt_n;
            WrStrobe  <= wr;
            ErrFlags  <= err_n;
            if (clr)
                for (int k = 0; k < 16; k++) disp_buf[k] <= 8'h20;
            else if (wr)
                disp_buf[Addr[3:0]] <= cmd;
        end
    end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed scenario tests for the LCD bus responder
module tb_lcd_bus_responder;
    localparam int CMD = 20;
    localparam int CLR = 60;
    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [11:8]   LCD_Data = '0;
    logic          LCD_E = 1'b0;
    logic          LCD_RS = 1'b0;
    logic          LCD_RW = 1'b0;
    logic [8*16:1] DisplayOut;
    logic [6:0]    Addr;
    logic          DisplayOn, Busy, WrStrobe;
    logic [1:0]    ErrFlags;
    int checks = 0;
    int failures = 0;
    int strobes = 0;
    int busy_cnt = 0;
    logic [8*16:1] exp_disp;

    lcd_bus_responder #(.CmdCycles(CMD), .ClearCycles(CLR), .CntW(17)) dut (
        .Clk(Clk), .Rst(Rst), .LCD_Data(LCD_Data), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .DisplayOut(DisplayOut), .Addr(Addr), .DisplayOn(DisplayOn),
        .Busy(Busy), .WrStrobe(WrStrobe), .ErrFlags(ErrFlags)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (WrStrobe) strobes++;
        if (Busy) busy_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic nib(input logic [3:0] d, input logic rs, input logic rw);
        @(posedge Clk);
        #1;
        LCD_Data = d;
        LCD_RS = rs;
        LCD_RW = rw;
        LCD_E = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        LCD_E = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic rs);
        nib(b[7:4], rs, 1'b0);
        nib(b[3:0], rs, 1'b0);
    endtask

    task automatic cmd_wait(input logic [7:0] b, input logic rs);
        wr_byte(b, rs);
        idle(CMD + 5);
    endtask

    task automatic do_init;
        nib(4'h3, 1'b0, 1'b0); idle(CMD + 5);
        nib(4'h3, 1'b0, 1'b0); idle(CMD + 5);
        nib(4'h3, 1'b0, 1'b0); idle(CMD + 5);
        nib(4'h2, 1'b0, 1'b0); idle(CMD + 5);
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (DisplayOut !== {16{8'h20}}) begin
            failures++;
            $display("FAIL %s_disp got=%h exp=%h", tag, DisplayOut, {16{8'h20}});
        end
        checks++;
        if ({Addr, DisplayOn, Busy, WrStrobe, ErrFlags} !== 12'h000) begin
            failures++;
            $display("FAIL %s_ctl got addr=%h on=%b busy=%b wr=%b err=%b exp all zero",
                     tag, Addr, DisplayOn, Busy, WrStrobe, ErrFlags);
        end
    endtask

    task automatic test_reset;
        idle(3);
        check_reset_vals("reset");
        Rst = 1'b1;
    endtask

    task automatic test_init;
        do_init();
        checks++;
        if ({Busy, ErrFlags} !== 3'b000) begin
            failures++;
            $display("FAIL init_flags got busy=%b err=%b exp busy=0 err=00", Busy, ErrFlags);
        end
        checks++;
        if (DisplayOut !== {16{8'h20}}) begin
            failures++;
            $display("FAIL init_disp got=%h exp=%h", DisplayOut, {16{8'h20}});
        end
    endtask

    task automatic test_hello;
        busy_cnt = 0;
        wr_byte(8'h01, 1'b0);
        idle(CLR + 10);
        checks++;
        if (busy_cnt !== CLR) begin
            failures++;
            $display("FAIL clear_busy_len got=%0d exp=%0d", busy_cnt, CLR);
        end
        cmd_wait(8'h80, 1'b0);
        strobes = 0;
        cmd_wait(8'h48, 1'b1);
        cmd_wait(8'h45, 1'b1);
        cmd_wait(8'h4C, 1'b1);
        cmd_wait(8'h4C, 1'b1);
        cmd_wait(8'h4F, 1'b1);
        exp_disp = {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, {11{8'h20}}};
        checks++;
        if (DisplayOut !== exp_disp) begin
            failures++;
            $display("FAIL hello_disp got=%h exp=%h", DisplayOut, exp_disp);
        end
        checks++;
        if (Addr !== 7'd5) begin
            failures++;
            $display("FAIL hello_addr got=%h exp=05", Addr);
        end
        checks++;
        if (strobes !== 5) begin
            failures++;
            $display("FAIL hello_strobes got=%0d exp=5", strobes);
        end
    endtask

    task automatic test_boundary;
        cmd_wait(8'h8F, 1'b0);
        strobes = 0;
        cmd_wait(8'h41, 1'b1);
        cmd_wait(8'h42, 1'b1);
        exp_disp = {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, {10{8'h20}}, 8'h41};
        checks++;
        if (DisplayOut !== exp_disp) begin
            failures++;
            $display("FAIL edge15_disp got=%h exp=%h", DisplayOut, exp_disp);
        end
        checks++;
        if (Addr !== 7'h11 || strobes !== 1) begin
            failures++;
            $display("FAIL edge15_addr got addr=%h strobes=%0d exp addr=11 strobes=1", Addr, strobes);
        end
        cmd_wait(8'h04, 1'b0);
        cmd_wait(8'h80, 1'b0);
        cmd_wait(8'h43, 1'b1);
        exp_disp = {8'h43, 8'h45, 8'h4C, 8'h4C, 8'h4F, {10{8'h20}}, 8'h41};
        checks++;
        if (DisplayOut !== exp_disp || Addr !== 7'h7F) begin
            failures++;
            $display("FAIL dec_wrap got disp=%h addr=%h exp disp=%h addr=7f", DisplayOut, Addr, exp_disp);
        end
        cmd_wait(8'h06, 1'b0);
        strobes = 0;
        cmd_wait(8'h5A, 1'b1);
        checks++;
        if (Addr !== 7'h00 || strobes !== 0 || DisplayOut !== exp_disp) begin
            failures++;
            $display("FAIL inc_wrap got addr=%h strobes=%0d disp=%h exp addr=00 strobes=0 disp=%h",
                     Addr, strobes, DisplayOut, exp_disp);
        end
    endtask

    task automatic test_ctrl;
        cmd_wait(8'h0C, 1'b0);
        checks++;
        if (DisplayOn !== 1'b1) begin
            failures++;
            $display("FAIL disp_on got=%b exp=1", DisplayOn);
        end
        cmd_wait(8'h08, 1'b0);
        checks++;
        if (DisplayOn !== 1'b0) begin
            failures++;
            $display("FAIL disp_off got=%b exp=0", DisplayOn);
        end
        cmd_wait(8'h83, 1'b0);
        cmd_wait(8'h40, 1'b0);
        strobes = 0;
        cmd_wait(8'h55, 1'b1);
        checks++;
        if (Addr !== 7'h03 || strobes !== 0 || DisplayOut !== exp_disp) begin
            failures++;
            $display("FAIL cgram got addr=%h strobes=%0d disp=%h exp addr=03 strobes=0 disp=%h",
                     Addr, strobes, DisplayOut, exp_disp);
        end
        cmd_wait(8'h80, 1'b0);
    endtask

    task automatic test_errors;
        cmd_wait(8'h81, 1'b0);
        wr_byte(8'h58, 1'b1);
        idle(5);
        wr_byte(8'h83, 1'b0);
        idle(CMD + 5);
        exp_disp = {8'h43, 8'h58, 8'h4C, 8'h4C, 8'h4F, {10{8'h20}}, 8'h41};
        checks++;
        if (ErrFlags !== 2'b01 || Addr !== 7'h03) begin
            failures++;
            $display("FAIL busy_err got err=%b addr=%h exp err=01 addr=03", ErrFlags, Addr);
        end
        checks++;
        if (DisplayOut !== exp_disp) begin
            failures++;
            $display("FAIL busy_err_disp got=%h exp=%h", DisplayOut, exp_disp);
        end
        nib(4'h8, 1'b0, 1'b1);
        idle(3);
        checks++;
        if (ErrFlags !== 2'b11) begin
            failures++;
            $display("FAIL rw_err got=%b exp=11", ErrFlags);
        end
        cmd_wait(8'h85, 1'b0);
        checks++;
        if (Addr !== 7'h05 || DisplayOut !== exp_disp) begin
            failures++;
            $display("FAIL rw_nostate got addr=%h disp=%h exp addr=05 disp=%h", Addr, DisplayOut, exp_disp);
        end
    endtask

    task automatic test_reset_mid;
        wr_byte(8'h20, 1'b0);
        nib(4'h4, 1'b1, 1'b0);
        Rst = 1'b0;
        #2;
        check_reset_vals("rst_mid");
        idle(2);
        Rst = 1'b1;
        strobes = 0;
        nib(4'h1, 1'b1, 1'b0);
        idle(CMD + 5);
        check_reset_vals("rst_junk");
        checks++;
        if (strobes !== 0) begin
            failures++;
            $display("FAIL rst_junk_strobe got=%0d exp=0", strobes);
        end
    endtask

    task automatic test_rs_flip;
        do_init();
        strobes = 0;
        nib(4'h4, 1'b1, 1'b0);
        nib(4'h1, 1'b0, 1'b0);
        idle(CMD + 5);
        checks++;
        if (ErrFlags !== 2'b10) begin
            failures++;
            $display("FAIL rs_flip_err got=%b exp=10", ErrFlags);
        end
        checks++;
        if (DisplayOut !== {8'h41, {15{8'h20}}} || Addr !== 7'h01 || strobes !== 1) begin
            failures++;
            $display("FAIL rs_flip_data got disp=%h addr=%h strobes=%0d exp disp=%h addr=01 strobes=1",
                     DisplayOut, Addr, strobes, {8'h41, {15{8'h20}}});
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_hello();
        test_boundary();
        test_ctrl();
        test_errors();
        test_reset_mid();
        test_rs_flip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
Behavioural responder for the 4-bit HD44780-style character LCD bus that our LCD driver path drives (LCD_Data[11:8], LCD_E, LCD_RS, LCD_RW). It decodes nibble transfers and executes the instruction subset we use. It maintains a 16-character line-1 display buffer, enforces instruction busy times and flags protocol violations. It is used in simulation and on-chip self-check to read back exactly what the driver painted onto the display.

Parameters:
CmdCycles, 2000, busy duration in Clk cycles after any instruction or data write except clear/home (40 us at 50 MHz)
ClearCycles, 82000, busy duration in Clk cycles after clear or return-home (1.64 ms at 50 MHz)
CntW, 17, busy counter width; must hold max(CmdCycles, ClearCycles)

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous, active-low reset
LCD_Data  in  [11:8]  nibble bus from driver
LCD_E  in  1  enable strobe; transfer executes on its falling edge
LCD_RS  in  1  0 = instruction, 1 = data
LCD_RW  in  1  0 = write; 1 = read (unsupported)
DisplayOut  out  [8*16:1]  buffer; char 0 (leftmost) at [8*16:8*15+1], char 15 at [8:1]
Addr  out  [6:0]  current DDRAM address counter
DisplayOn  out  1  display-control D bit
Busy  out  1  high while busy counter != 0
WrStrobe  out  1  one-cycle pulse when a character is stored into the buffer
ErrFlags  out  [1:0]  sticky; bit0 = access while busy, bit1 = RW=1 or RS mismatch between nibbles

Behaviour:
- Reset (Rst=0, async): every buffer byte = 8'h20; Addr = 0; I/D = 1; mode = DDRAM; DisplayOn = 0; Busy = 0; WrStrobe = 0; ErrFlags = 0; state = INIT8.
- E edge detect: register E_d. While LCD_E=1, latch LCD_Data, LCD_RS and LCD_RW every cycle. A fall is E_d=1 and LCD_E=0, and it uses the latched values. Each fall is one nibble event; its effects are visible the next cycle.
- RW=1 at a fall: set ErrFlags[1]. Ignore the nibble with no state advance.
- State INIT8: each nibble is treated as an 8-bit-mode instruction holding only its upper nibble.
  - Nibble 4'h3 with RS=0: no action, stay in INIT8.
  - Nibble 4'h2 with RS=0: go to NIB_HI (4-bit mode).
  - Anything else: ignore.
  - INIT8 nibbles do not start the busy counter.
- State NIB_HI: store the nibble as the high half and record RS; go to NIB_LO.
- State NIB_LO: form byte = {hi, lo}. If RS differs from the recorded RS, set ErrFlags[1] and use the recorded RS. Execute, then return to NIB_HI.
- Instruction execute (RS=0), priority on the MSB set:
  - 1xxxxxxx: Addr = byte[6:0]; mode = DDRAM.
  - 01xxxxxx: mode = CGRAM; subsequent data writes are discarded, and Addr is unchanged.
  - 001xxxxx: function set; ignored.
  - 0001xxxx: if bit3=0, cursor move: Addr +1 when bit2=1, else -1, 7-bit wrap. If bit3=1 (display shift), ignored.
  - 00001xxx: DisplayOn = bit2.
  - 000001xx: I/D = bit1; shift bit ignored.
  - 0000001x: Addr = 0; mode = DDRAM; busy = ClearCycles.
  - 00000001: all buffer bytes = 8'h20; Addr = 0; I/D = 1; mode = DDRAM; busy = ClearCycles.
  - 00000000: no-op.
  - Every case except clear and home loads busy = CmdCycles.
- Data execute (RS=1):
  - If mode = DDRAM and Addr < 16: buffer[Addr] = byte and WrStrobe pulses.
  - Addr then moves +1 if I/D=1, else -1, modulo 128 in both directions (7'h7F+1 = 0, 0-1 = 7'h7F).
  - Writes with Addr >= 16 only move Addr.
  - In CGRAM mode the byte is discarded and Addr is unchanged.
  - Busy = CmdCycles.
- Busy counter: decrements by 1 per cycle while nonzero; Busy = (counter != 0).
- A nibble fall in NIB_HI or NIB_LO while Busy=1 sets ErrFlags[0]. The nibble is still processed normally, and a completed instruction reloads the counter.
- A fall in the same cycle the counter reads 1 counts as busy. A fall when it reads 0 does not.
- ErrFlags clear only on reset.
- Reset mid-transfer (between nibbles or during busy) discards the partial byte and returns to INIT8. No WrStrobe is issued.

Test Plan:
1. Reset, then init nibbles 3,3,3,2 (RS=0), each followed by >CmdCycles idle -> state NIB_HI; Busy=0, ErrFlags=0, DisplayOut all 8'h20.
2. After init: 0x01, wait ClearCycles; 0x80; data "HELLO" spaced CmdCycles -> DisplayOut chars 0..4 = 48 45 4C 4C 4F, rest 20. Addr=5; five WrStrobe pulses; Busy high exactly ClearCycles cycles after the clear fall.
3. 0x8F, write 'A' then 'B' -> char 15 = 8'h41, Addr=7'h11, 'B' not stored, one WrStrobe. Then 0x04 (I/D=0), 0x80, write 'C' -> char 0 = 8'h43, Addr=7'h7F.
4. Send a byte high nibble 5 cycles after a data write (CmdCycles=2000) -> ErrFlags=2'b01 and the byte still executes. With RS flipped between nibbles -> ErrFlags[1]=1. With LCD_RW=1 on a strobe -> ErrFlags[1]=1, state unchanged.
5. 0x0C -> DisplayOn=1; 0x08 -> DisplayOn=0; 0x40 then data 0x55 -> buffer and Addr unchanged, no WrStrobe.
6. Assert Rst after the first nibble of a data byte -> all outputs return to reset values immediately; the second nibble is ignored as INIT8 junk and the buffer stays 8'h20.
